// File: rtl/ecc_pkg.sv
// Shared P-256 constants and types for the ECDHE key path.
// Used by the public-key serializer and the coordinate range checker.
package ecc_pkg;

    localparam int COORD_W = 256;

    localparam logic [COORD_W-1:0] P256_PRIME =
        256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    localparam logic [7:0] SEC1_UNCOMPRESSED = 8'h04;

    // Prefix byte plus both coordinates.
    localparam int FRAME_LEN = 1 + 2 * (COORD_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SEND
    } state_t;

endpackage

// File: rtl/p256_coord_check.sv
// Combinational P-256 point range check: both coordinates below p and
// not the all-zero pair. Shared with the future peer-key receive path.
module p256_coord_check
    import ecc_pkg::*;
(
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               ok_o
);

    assign ok_o = (x_i < P256_PRIME) && (y_i < P256_PRIME) && ((x_i | y_i) != '0);

endmodule

// File: rtl/ecdhe_pubkey_serializer.sv
// Captures the generated public key, range-checks it, and streams it as a
// 65-byte SEC1 uncompressed point (0x04 || X || Y) over a byte stream.
module ecdhe_pubkey_serializer #(
    parameter logic [7:0] PREFIX  = ecc_pkg::SEC1_UNCOMPRESSED,
    parameter int         COORD_W = ecc_pkg::COORD_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key_valid_i,
    input  logic [2*COORD_W-1:0] public_key_i,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 key_err_o,
    output logic                 overrun_o
);

    localparam int         KEY_W    = 2 * COORD_W;
    localparam logic [6:0] LAST_IDX = 7'(ecc_pkg::FRAME_LEN - 1);

    ecc_pkg::state_t    state_q;
    logic [KEY_W-1:0]   key_q;
    logic [6:0]         idx_q;
    logic [7:0]         tdata_q;
    logic               tvalid_q;
    logic               tlast_q;
    logic               done_q;
    logic               key_err_q;
    logic               key_ok;

    p256_coord_check u_coord_check (
        .x_i  (key_q[KEY_W-1 -: COORD_W]),
        .y_i  (key_q[COORD_W-1:0]),
        .ok_o (key_ok)
    );

    // key_q doubles as the output shifter: each accepted byte shifts zeros
    // in from the bottom, so the key is also wiped as it is sent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ecc_pkg::ST_IDLE;
            key_q     <= '0;
            idx_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
            case (state_q)
                ecc_pkg::ST_IDLE: begin
                    if (key_valid_i) begin
                        key_q   <= public_key_i;
                        state_q <= ecc_pkg::ST_CHECK;
                    end
                end
                ecc_pkg::ST_CHECK: begin
                    if (!key_ok) begin
                        key_err_q <= 1'b1;
                        key_q     <= '0;
                        state_q   <= ecc_pkg::ST_IDLE;
                    end else begin
                        idx_q    <= '0;
                        tdata_q  <= PREFIX;
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                        state_q  <= ecc_pkg::ST_SEND;
                    end
                end
                ecc_pkg::ST_SEND: begin
                    if (m_tready) begin
                        if (idx_q == LAST_IDX) begin
                            key_q    <= '0;
                            idx_q    <= '0;
                            tdata_q  <= '0;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= ecc_pkg::ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + 7'd1;
                            tdata_q <= key_q[KEY_W-1 -: 8];
                            key_q   <= key_q << 8;
                            tlast_q <= (idx_q == LAST_IDX - 7'd1);
                        end
                    end
                end
                default: state_q <= ecc_pkg::ST_IDLE;
            endcase
        end
    end

    assign m_tdata   = tdata_q;
    assign m_tvalid  = tvalid_q;
    assign m_tlast   = tlast_q;
    assign done_o    = done_q;
    assign key_err_o = key_err_q;
    assign busy_o    = (state_q != ecc_pkg::ST_IDLE);
    // Flags a key offered in the very cycle it is being dropped.
    assign overrun_o = key_valid_i && (state_q != ecc_pkg::ST_IDLE);

endmodule

// File: tb/tb_ecdhe_pubkey_serializer.sv
// Scoreboard bench for the SEC1 public-key serializer: expected frames are
// queued at issue time and a negedge monitor checks every accepted byte.
module tb_ecdhe_pubkey_serializer;

    localparam logic [255:0] P  = 256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] GX = 256'h6B17D1F2_E12C4247_F8BCE6E5_63A440F2_77037D81_2DEB33A0_F4A13945_D898C296;
    localparam logic [255:0] GY = 256'h4FE342E2_FE1A7F9B_8EE7EB4A_7C0F9E16_2BCE3357_6B315ECE_CBB64068_37BF51F5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         key_valid_i = 1'b0;
    logic [511:0] public_key_i = '0;
    logic         m_tready = 1'b0;
    logic [7:0]   m_tdata;
    logic         m_tvalid, m_tlast, busy_o, done_o, key_err_o, overrun_o;

    ecdhe_pubkey_serializer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_valid_i  (key_valid_i),
        .public_key_i (public_key_i),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .key_err_o    (key_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: the acceptance rule and the frame layout, straight from arithmetic.
    function automatic bit key_ok(input logic [255:0] x, input logic [255:0] y);
        return (x < P) && (y < P) && !(x == 0 && y == 0);
    endfunction

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;
    beat_t exp_q[$];

    task automatic push_frame(input logic [511:0] k);
        beat_t b;
        b.d = 8'h04; b.l = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < 64; i++) begin
            b.d = k[511 - 8*i -: 8];
            b.l = (i == 63);
            exp_q.push_back(b);
        end
    endtask

    // Monitor / scoreboard
    int   done_cnt = 0, err_cnt = 0, ovr_cnt = 0, acc_cnt = 0;
    int   last_hs_cyc = -100, err_cyc = -1, ovr_cyc = -1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    logic prev_l = 1'b0;

    always @(negedge clk) begin
        beat_t b;
        if (!reset_n) begin
            chk("reset_outputs", {m_tdata, m_tvalid, m_tlast, busy_o, done_o, key_err_o, overrun_o}, 64'd0);
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_tvalid", m_tvalid, 1);
                chk("stall_tdata", m_tdata, prev_d);
                chk("stall_tlast", m_tlast, prev_l);
            end
            if (!m_tvalid) chk("idle_tdata_zero", m_tdata, 0);
            if (m_tvalid && m_tready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte at cycle %0d: got %0h expected no byte", cyc, m_tdata);
                end else begin
                    b = exp_q.pop_front();
                    chk("byte_data", m_tdata, b.d);
                    chk("byte_last", m_tlast, b.l);
                    if (b.l) last_hs_cyc = cyc;
                end
            end
            if (done_o) begin
                done_cnt++;
                chk("done_after_last", cyc, last_hs_cyc + 1);
            end
            if (key_err_o) begin err_cnt++; err_cyc = cyc; end
            if (overrun_o) begin ovr_cnt++; ovr_cyc = cyc; end
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
        end
    end

    // Sink: always ready, or random stalls of at least three cycles
    int rdy_mode = 0;
    int low_left = 0;
    initial forever begin
        @(posedge clk); #1;
        if (rdy_mode == 0) m_tready = 1'b1;
        else if (low_left > 0) begin m_tready = 1'b0; low_left--; end
        else if ($urandom_range(0, 3) == 0) begin m_tready = 1'b0; low_left = $urandom_range(2, 5); end
        else m_tready = 1'b1;
    end

    task automatic issue(input logic [511:0] k, output int t);
        @(posedge clk); #1;
        key_valid_i = 1'b1;
        public_key_i = k;
        t = cyc;
        @(posedge clk); #1;
        key_valid_i = 1'b0;
        public_key_i = '0;
    endtask

    task automatic at_neg(input int c);
        while (1) begin
            @(negedge clk);
            if (cyc >= c) break;
        end
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
        chk("done_reached", done_cnt >= target, 1);
    endtask

    function automatic logic [511:0] rand_key();
        logic [511:0] k;
        for (int w = 0; w < 16; w++) k[32*w +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        int t, d0, e0, o0, a0, n;
        logic [511:0] k;
        logic [255:0] x, y;

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Generator point, sink always ready, cycle-exact timing
        rdy_mode = 0;
        push_frame({GX, GY});
        issue({GX, GY}, t);
        for (int c = t + 1; c <= t + 68; c++) begin
            at_neg(c);
            chk("busy_window", busy_o, (c <= t + 66));
            chk("tvalid_window", m_tvalid, (c >= t + 2 && c <= t + 66));
            chk("tlast_window", m_tlast, (c == t + 66));
            chk("done_timing", done_o, (c == t + 67));
        end
        chk("frame1_consumed", exp_q.size(), 0);

        // Same key, random back-pressure
        rdy_mode = 1;
        d0 = done_cnt;
        push_frame({GX, GY});
        issue({GX, GY}, t);
        wait_done(d0 + 1, 3000);
        repeat (20) @(negedge clk);
        chk("stall_done_once", done_cnt, d0 + 1);
        chk("stall_frame_consumed", exp_q.size(), 0);
        rdy_mode = 0;
        repeat (8) @(posedge clk);

        // X = p, Y = 1: rejected
        e0 = err_cnt;
        issue({P, 256'd1}, t);
        at_neg(t + 1);
        chk("badp_busy_check", busy_o, 1);
        chk("badp_err_early", key_err_o, 0);
        at_neg(t + 2);
        chk("badp_key_err", key_err_o, 1);
        chk("badp_busy_low", busy_o, 0);
        chk("badp_tvalid", m_tvalid, 0);
        at_neg(t + 3);
        chk("badp_err_pulse", key_err_o, 0);
        chk("badp_tvalid_after", m_tvalid, 0);
        chk("badp_err_count", err_cnt, e0 + 1);

        // X = Y = 0: rejected
        e0 = err_cnt;
        issue(512'd0, t);
        at_neg(t + 4);
        chk("zero_err_count", err_cnt, e0 + 1);
        chk("zero_err_cycle", err_cyc, t + 2);
        chk("zero_tvalid", m_tvalid, 0);

        // Overrun mid-frame: second key ignored
        o0 = ovr_cnt; d0 = done_cnt;
        push_frame({GX, GY});
        issue({GX, GY}, t);
        to_cycle(t + 10);
        key_valid_i = 1'b1;
        public_key_i = {GY, GX};
        at_neg(t + 10);
        chk("overrun_pulse", overrun_o, 1);
        @(posedge clk); #1;
        key_valid_i = 1'b0;
        public_key_i = '0;
        wait_done(d0 + 1, 200);
        repeat (10) @(negedge clk);
        chk("overrun_count", ovr_cnt, o0 + 1);
        chk("overrun_cycle", ovr_cyc, t + 10);
        chk("overrun_no_second_frame", m_tvalid, 0);
        chk("overrun_frame_consumed", exp_q.size(), 0);

        // Overrun on the final handshake cycle: not captured
        o0 = ovr_cnt;
        push_frame({GX, GY});
        issue({GX, GY}, t);
        to_cycle(t + 66);
        key_valid_i = 1'b1;
        public_key_i = {GX, GY};
        at_neg(t + 66);
        chk("lastbeat_overrun", overrun_o, 1);
        @(posedge clk); #1;
        key_valid_i = 1'b0;
        public_key_i = '0;
        at_neg(t + 68);
        chk("lastbeat_not_captured", busy_o, 0);
        chk("lastbeat_overrun_count", ovr_cnt, o0 + 1);

        // Reset at byte 20, then the key is reissued
        a0 = acc_cnt; d0 = done_cnt;
        push_frame({GX, GY});
        issue({GX, GY}, t);
        n = 0;
        while (acc_cnt < a0 + 20 && n < 200) begin @(negedge clk); n++; end
        chk("reset_byte20_reached", acc_cnt >= a0 + 20, 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_no_done", done_cnt, d0);
        chk("reset_no_resume", m_tvalid, 0);
        push_frame({GX, GY});
        issue({GX, GY}, t);
        wait_done(d0 + 1, 200);
        chk("reset_reissue_consumed", exp_q.size(), 0);

        // Randomized keys, including range boundaries
        for (int it = 0; it < 10; it++) begin
            k = rand_key();
            x = k[511:256];
            y = k[255:0];
            case ($urandom_range(0, 5))
                0: x = P;
                1: y = P - 256'd1;
                2: begin x = '0; y = '0; end
                3: y = '1;
                default: ;
            endcase
            k = {x, y};
            rdy_mode = it % 2;
            if (key_ok(x, y)) begin
                d0 = done_cnt;
                push_frame(k);
                issue(k, t);
                wait_done(d0 + 1, 3000);
                chk("rand_frame_consumed", exp_q.size(), 0);
            end else begin
                e0 = err_cnt;
                issue(k, t);
                at_neg(t + 3);
                chk("rand_err_count", err_cnt, e0 + 1);
                chk("rand_err_cycle", err_cyc, t + 2);
            end
            repeat (3) @(posedge clk);
        end

        rdy_mode = 0;
        repeat (10) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ecdhe_pubkey_serializer.md
# ecdhe_pubkey_serializer

Downstream stage of the ECDHE key generator. It captures the 512-bit public key (X‖Y) on the generator's completion pulse and range-checks both coordinates against the P-256 prime. Valid keys are streamed out as a 65-byte SEC1 uncompressed point (0x04‖X‖Y, big-endian) on an AXI-Stream-style byte interface toward the handshake/transport logic.

## Interface
Parameters:
- PREFIX, 8'h04, first byte of every frame (SEC1 uncompressed tag)
- COORD_W, 256, coordinate width in bits; fixed for P-256, not intended to be overridden

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- key_valid_i  in  1  single-cycle pulse: public_key_i is valid (generator complete)
- public_key_i  in  512  {X[255:0], Y[255:0]}
- m_tdata  out  8  stream byte
- m_tvalid  out  1  stream byte valid
- m_tready  in  1  sink ready
- m_tlast  out  1  high on byte 64 (final byte)
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse after the final byte handshake
- key_err_o  out  1  one-cycle pulse: captured key rejected
- overrun_o  out  1  one-cycle pulse: key_valid_i arrived while busy

## Operation
- States: IDLE, CHECK, SEND.
- IDLE:
  - On key_valid_i: latch public_key_i into the internal 512-bit register, go to CHECK.
- CHECK (exactly 1 cycle):
  - Key is bad if X ≥ p, or Y ≥ p, or X = Y = 0, with p = FFFFFFFF00000001 00000000 00000000 00000000 FFFFFFFF FFFFFFFF FFFFFFFF (hex, 256 bits).
  - Bad key: pulse key_err_o, clear the register, return to IDLE. No bytes are emitted.
  - Good key: byte index ← 0, go to SEND.
- SEND:
  - m_tvalid = 1.
  - Byte 0 is PREFIX; bytes 1..32 are X MSB-first; bytes 33..64 are Y MSB-first.
  - 7-bit byte index; it advances only on m_tvalid && m_tready.
  - m_tlast = 1 exactly when index = 64.
  - Handshake on index 64: clear the register to zero (key material zeroized), go to IDLE, and assert done_o on the next cycle.
- AXI rules:
  - m_tdata and m_tlast are stable while m_tvalid && !m_tready.
  - m_tvalid never drops once raised, until the last-byte handshake.
  - The block never waits on m_tready before asserting m_tvalid.
- key_valid_i in CHECK or SEND: ignored (the in-flight frame is unaffected), overrun_o pulses that cycle.
- key_valid_i in the same cycle that SEND returns to IDLE: treated as busy, so overrun_o pulses and the key is not captured.
- Range check is a pure combinational 256-bit compare on the registered value; no arithmetic beyond the compare.

## Timing
- Reset values: m_tdata = 0, m_tvalid = 0, m_tlast = 0, busy_o = 0, done_o = 0, key_err_o = 0, overrun_o = 0; state = IDLE; register and index = 0.
- key_valid_i at cycle T:
  - CHECK at T+1.
  - First m_tvalid at T+2.
- With m_tready held 1:
  - Bytes are accepted on cycles T+2..T+66.
  - done_o at T+67.
  - busy_o is high T+1..T+66.
- Bad key: key_err_o at T+2, busy_o low at T+2.
- m_tdata is 0 whenever m_tvalid = 0.
- reset_n asserted mid-frame: all outputs and the register clear immediately. No partial frame resumes and no done_o is issued.

## Structure
- Shared package (ecc_pkg): P256_PRIME, COORD_W, SEC1_UNCOMPRESSED = 8'h04, frame length constant 65, state enum.
- Sub-module p256_coord_check: combinational; takes X and Y, outputs a single ok bit. Reusable by a future peer-key receive path.
- Byte selection uses a left-shifting 512-bit register plus the index. No wide mux over the index is required.

## Test plan
- Generator point (X=6B17D1F2…D898C296, Y=4FE342E2…37BF51F5), m_tready = 1:
  - Bytes 04,6B,17,…,96,4F,E3,…,F5.
  - m_tlast only on the 65th byte; done_o at T+67.
- Same key with m_tready toggled randomly (low ≥ 3 cycles at a time):
  - Identical byte sequence.
  - m_tdata and m_tlast stable during every stall.
  - done_o exactly once.
- X = p, Y = 1:
  - key_err_o at T+2; m_tvalid never rises; busy_o low at T+2.
- X = Y = 0:
  - key_err_o pulse; no frame.
- Overrun: a second key_valid_i at T+10 during a frame:
  - overrun_o pulse at T+10.
  - The frame still carries the first key.
  - The second key is never emitted.
- Reset asserted at byte 20, then the generator-point key is reissued:
  - All outputs 0 during reset.
  - The new frame starts cleanly with 04, 6B.
  - No residual bytes from the aborted frame.
